tcm_dport_arbiter: RTL
======================

# tcm_dport_arbiter

Arbiter and sequencer for the TCM store-buffer data port. It shares the single `bus_tcm_stbuf_*` read/write port between the load/store unit (LSU) and the debug/DMA master (DBG). It also tracks the 1-cycle TCM read latency so each read response is routed to its owner, and it checks size and alignment before any TCM strobe is driven. It sits between the LSU/debug modules and the `tcm` data port; the fetch port is not touched.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width (read and write)
- `SIZE_WIDTH`, 3, access-size field width (byte count: 1, 2, 4)
- `STARVE_LIMIT`, 4, consecutive lost DBG cycles before DBG is forced to win (≥1)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous and active-low (0 = reset)
- `lsu_req`, `dbg_req`  in  1  access request, held until granted
- `lsu_we`, `dbg_we`  in  1  1 = write, 0 = read
- `lsu_addr`, `dbg_addr`  in  ADDR_WIDTH  byte address
- `lsu_size`, `dbg_size`  in  SIZE_WIDTH  byte count
- `lsu_wdata`, `dbg_wdata`  in  DATA_WIDTH  write data, LSB-aligned
- `dbg_lock`  in  1  sampled with a granted DBG request; holds the port for DBG
- `lsu_gnt`, `dbg_gnt`  out  1  combinational grant, same cycle as request
- `lsu_rvalid`, `dbg_rvalid`  out  1  read data valid, one cycle after the grant
- `lsu_rdata`, `dbg_rdata`  out  DATA_WIDTH  read data, zero-extended to the access size
- `lsu_err`, `dbg_err`  out  1  one-cycle pulse, one cycle after the grant of an illegal access
- `bus_tcm_stbuf_read_addr`, `bus_tcm_stbuf_write_addr`  out  ADDR_WIDTH  TCM addresses
- `bus_tcm_stbuf_read_size`, `bus_tcm_stbuf_write_size`  out  SIZE_WIDTH  TCM sizes
- `bus_tcm_stbuf_data`  out  DATA_WIDTH  TCM write data
- `bus_tcm_stbuf_rd`, `bus_tcm_stbuf_wr`  out  1  TCM strobes
- `tcm_bus_stbuf_data`  in  DATA_WIDTH  TCM read data, valid the cycle after `rd`

## Operation
**Grant rule**
- At most one grant per cycle.
- `gnt` is asserted only when the matching `req` is high.

**States**
- ARB:
  - LSU has priority.
  - If DBG lost while requesting, `starve_cnt` increments (saturating).
  - When `starve_cnt == STARVE_LIMIT` and `dbg_req` is high, DBG wins and `starve_cnt` clears.
  - Any DBG grant clears `starve_cnt`.
- A DBG grant with `dbg_lock=1` moves the state to DBG_LOCKED.
- DBG_LOCKED:
  - Only DBG can be granted; `lsu_gnt=0`.
  - `starve_cnt` is held.
  - The state returns to ARB on the first cycle with `dbg_lock=0`. That cycle arbitrates as ARB; `dbg_lock` is sampled independently of `dbg_req`.

**Legality**
- `size ∈ {1,2,4}` and `addr % size == 0`.
- An illegal access is still granted, but no TCM strobe is driven. The owner's `err` pulses the next cycle and its `rvalid` stays 0.

**Granted legal access**
- Read:
  - `rd=1`; `read_addr`/`read_size` come from the winner.
  - `write_addr`/`write_size`/`data` are held at 0.
- Write:
  - `wr=1`; `write_addr`/`write_size`/`data` come from the winner.
  - `read_addr`/`read_size` are held at 0.

**Response pipeline**
- One register holds {valid, owner, size}.
- Next cycle: the owner's `rvalid=1`, and `rdata = tcm_bus_stbuf_data` masked to 8, 16 or 32 bits.
- The non-owner's `rdata` is 0.

## Timing
- Reset (`rst=0`, asynchronous):
  - State ARB, `starve_cnt=0`, response register cleared.
  - All `gnt`, `rvalid`, `err`, `rd` and `wr` outputs are 0, and all `rdata` is 0 (grants are gated by reset).
- Grant and TCM strobes are combinational in cycle N; `rvalid`/`err` come in cycle N+1. Back-to-back reads sustain 1 read/cycle.
- Simultaneous events:
  - A read followed immediately by a write from either requester is legal.
  - The N+1 response is unaffected by the N+1 grant.
- Reset mid-read:
  - The pending response is dropped; no `rvalid` after reset release.
  - A request still held at release is granted in the first cycle with `rst=1`.
- A requester must not change `addr`/`we`/`size`/`wdata` while waiting for `gnt`.

## Test plan
- **Reset:** `rst=0` with both `req=1` → all grants and strobes 0. Release → `lsu_gnt=1` in the same cycle.
- **Read routing:** LSU read addr 0x100, size 4 → `rd=1`, `read_addr=0x100` in cycle N. In N+1, `lsu_rvalid=1` and `lsu_rdata` equals the TCM word; `dbg_rvalid=0`.
- **Size masking:** DBG read addr 0x103, size 1, TCM returns 0xAABBCCDD → `dbg_rdata=0x000000DD`.
- **Starvation:** with `STARVE_LIMIT=4`, both request continuously → LSU wins 4 cycles, DBG wins cycle 5, LSU wins cycle 6.
- **Lock:** DBG granted with `dbg_lock=1` for 3 cycles while `lsu_req=1` → `lsu_gnt=0` for those 3 cycles. The first cycle with `dbg_lock=0` grants LSU.
- **Illegal access:** LSU write addr 0x102, size 4 → `lsu_gnt=1` with `wr=0`; `lsu_err=1` next cycle. A size-3 DBG read also errors, with `rd=0` and no `rvalid`.

Source files
------------

// File: rtl/tcm_dport_arbiter.sv
// Shares the TCM store-buffer port between LSU and DBG. Grants and strobes are combinational in cycle N, and rvalid/err follow in N+1.
// Backpressure: a requester holds req until granted. LSU has priority, and DBG escapes starvation after STARVE_LIMIT lost cycles.
module tcm_dport_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [SIZE_WIDTH-1:0] lsu_size,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [SIZE_WIDTH-1:0] dbg_size,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_err,

    output logic [ADDR_WIDTH-1:0] bus_tcm_stbuf_read_addr,
    output logic [ADDR_WIDTH-1:0] bus_tcm_stbuf_write_addr,
    output logic [SIZE_WIDTH-1:0] bus_tcm_stbuf_read_size,
    output logic [SIZE_WIDTH-1:0] bus_tcm_stbuf_write_size,
    output logic [DATA_WIDTH-1:0] bus_tcm_stbuf_data,
    output logic                  bus_tcm_stbuf_rd,
    output logic                  bus_tcm_stbuf_wr,
    input  logic [DATA_WIDTH-1:0] tcm_bus_stbuf_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ARB,
        DBG_LOCKED
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic                  owner_dbg;
        logic [SIZE_WIDTH-1:0] size;
    } resp_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    resp_t            resp_q;
    resp_t            resp_d;

    logic                  arb_mode;
    logic                  dbg_force;
    logic                  lsu_win;
    logic                  dbg_win;
    logic                  any_win;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [SIZE_WIDTH-1:0] sel_size;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  legal;
    logic [DATA_WIDTH-1:0] rmask;
    logic [DATA_WIDTH-1:0] rdata_masked;

    // A locked cycle that drops dbg_lock arbitrates as a normal ARB cycle.
    always_comb begin
        arb_mode  = (state == ARB) || !dbg_lock;
        dbg_force = (starve_cnt == CNT_W'(STARVE_LIMIT));
        dbg_win   = 1'b0;
        lsu_win   = 1'b0;
        if (arb_mode) begin
            dbg_win = dbg_req && (!lsu_req || dbg_force);
            lsu_win = lsu_req && !dbg_win;
        end else begin
            dbg_win = dbg_req;
        end
        any_win = lsu_win || dbg_win;
    end

    assign lsu_gnt = lsu_win && rst;
    assign dbg_gnt = dbg_win && rst;
    assign any_gnt = lsu_gnt || dbg_gnt;

    always_comb begin
        sel_we    = dbg_win ? dbg_we    : lsu_we;
        sel_addr  = dbg_win ? dbg_addr  : lsu_addr;
        sel_size  = dbg_win ? dbg_size  : lsu_size;
        sel_wdata = dbg_win ? dbg_wdata : lsu_wdata;
        legal     = (sel_size == SIZE_WIDTH'(1))
                 || ((sel_size == SIZE_WIDTH'(2)) && !sel_addr[0])
                 || ((sel_size == SIZE_WIDTH'(4)) && (sel_addr[1:0] == 2'b00));
    end

    always_comb begin
        bus_tcm_stbuf_rd         = any_gnt && !sel_we && legal;
        bus_tcm_stbuf_wr         = any_gnt &&  sel_we && legal;
        bus_tcm_stbuf_read_addr  = bus_tcm_stbuf_rd ? sel_addr  : '0;
        bus_tcm_stbuf_read_size  = bus_tcm_stbuf_rd ? sel_size  : '0;
        bus_tcm_stbuf_write_addr = bus_tcm_stbuf_wr ? sel_addr  : '0;
        bus_tcm_stbuf_write_size = bus_tcm_stbuf_wr ? sel_size  : '0;
        bus_tcm_stbuf_data       = bus_tcm_stbuf_wr ? sel_wdata : '0;
    end

    always_comb begin
        resp_d           = '0;
        resp_d.vld       = any_win && !sel_we && legal;
        resp_d.err       = any_win && !legal;
        resp_d.owner_dbg = dbg_win;
        resp_d.size      = sel_size;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            resp_q     <= '0;
        end else begin
            resp_q <= resp_d;
            if (dbg_lock && ((state == DBG_LOCKED) || dbg_win)) begin
                state <= DBG_LOCKED;
            end else begin
                state <= ARB;
            end
            // The counter is frozen while the port is locked to DBG.
            if (arb_mode) begin
                if (dbg_win) begin
                    starve_cnt <= '0;
                end else if (dbg_req && !dbg_force) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        case (resp_q.size)
            SIZE_WIDTH'(1): rmask = DATA_WIDTH'(8'hFF);
            SIZE_WIDTH'(2): rmask = DATA_WIDTH'(16'hFFFF);
            default:        rmask = '1;
        endcase
        rdata_masked = tcm_bus_stbuf_data & rmask;
    end

    assign lsu_rvalid = resp_q.vld && !resp_q.owner_dbg;
    assign dbg_rvalid = resp_q.vld &&  resp_q.owner_dbg;
    assign lsu_err    = resp_q.err && !resp_q.owner_dbg;
    assign dbg_err    = resp_q.err &&  resp_q.owner_dbg;
    assign lsu_rdata  = lsu_rvalid ? rdata_masked : '0;
    assign dbg_rdata  = dbg_rvalid ? rdata_masked : '0;

endmodule
